// File: rtl/fir_coef_bank.sv
`timescale 1ns/1ps
module fir_coef_bank #(
  parameter int unsigned NUM_COEF  = 32,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned SAMPLES_W = 14,
  parameter int unsigned CW        = $clog2(NUM_COEF)
) (
  input  logic                 clk_b,
  input  logic                 rst,
  input  logic [31:0]          PADDR,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [31:0]          PWDATA,
  output logic                 PREADY,
  output logic [31:0]          PRDATA,
  output logic                 PSLVERR,
  input  logic [CW-1:0]        fir_coef_addr,
  output logic [COEF_W-1:0]    fir_coef_data,
  output logic                 start,
  input  logic                 busy,
  input  logic                 done,
  output logic [CW:0]          ile_wsp,
  output logic [SAMPLES_W-1:0] ile_probek,
  output logic                 irq
);

  typedef enum logic [1:0] {S_IDLE, S_RAM_WAIT, S_RESP} apb_state_t;

  apb_state_t state_q, state_d;

  logic              access;
  logic [9:0]        word;
  logic [9:0]        coef_off;
  logic [CW-1:0]     acc_idx;
  logic              is_reg;
  logic              is_coef;
  logic              acc_err;
  logic [31:0]       reg_rdata;

  logic              wr_q;
  logic              err_q;
  logic [9:0]        word_q;
  logic [CW-1:0]     idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       prdata_q;

  logic              active_bank;
  logic              swap_pending;
  logic              done_sticky;
  logic              irq_en;

  logic              commit;
  logic              swap_req;

  logic [COEF_W-1:0] coef_mem [2][NUM_COEF];
  logic [COEF_W-1:0] ram_rd_q;

  logic              unused_ok;

  assign access   = PSEL & PENABLE;
  assign word     = PADDR[11:2];
  assign coef_off = word - 10'd256;
  assign acc_idx  = coef_off[CW-1:0];
  assign is_reg   = (word < 10'd4);
  assign is_coef  = (word >= 10'd256) && ({22'd0, coef_off} < NUM_COEF);

  // Errors are judged on the bus state at ACCESS and carried to RESP.
  always_comb begin
    acc_err = !(is_reg || is_coef);
    if (PWRITE) begin
      if ((word == 10'd0) && PWDATA[0] && busy)              acc_err = 1'b1;
      if (((word == 10'd2) || (word == 10'd3)) && busy)      acc_err = 1'b1;
      if ((word == 10'd2) && ((PWDATA == 32'd0) || (PWDATA > NUM_COEF)))
        acc_err = 1'b1;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (is_reg) begin
      case (word[1:0])
        2'd0:    reg_rdata = {29'd0, irq_en, 2'b00};
        2'd1:    reg_rdata = {28'd0, done_sticky, swap_pending, active_bank, busy};
        2'd2:    reg_rdata = 32'(ile_wsp);
        default: reg_rdata = 32'(ile_probek);
      endcase
    end
  end

  always_ff @(posedge clk_b) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (access)
          state_d = (!PWRITE && is_coef) ? S_RAM_WAIT : S_RESP;
      S_RAM_WAIT: state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign commit   = (state_q == S_RESP) && wr_q && !err_q;
  assign swap_req = commit && (word_q == 10'd0) && wdata_q[1];

  always_ff @(posedge clk_b) begin
    if (rst) begin
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      word_q        <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      prdata_q      <= '0;
      active_bank   <= 1'b0;
      swap_pending  <= 1'b0;
      done_sticky   <= 1'b0;
      irq_en        <= 1'b0;
      start         <= 1'b0;
      ile_wsp       <= (CW+1)'(NUM_COEF);
      ile_probek    <= '0;
      fir_coef_data <= '0;
    end else begin
      fir_coef_data <= coef_mem[active_bank][fir_coef_addr];
      start         <= 1'b0;

      if (state_q == S_IDLE && access) begin
        wr_q     <= PWRITE;
        err_q    <= acc_err;
        word_q   <= word;
        idx_q    <= acc_idx;
        wdata_q  <= PWDATA;
        prdata_q <= reg_rdata;
      end
      if (state_q == S_RAM_WAIT)
        prdata_q <= 32'(ram_rd_q);

      // A pending swap retires on done; a swap request arriving together
      // with done while busy toggles once and never becomes pending.
      if (swap_pending) begin
        if (done) begin
          active_bank  <= ~active_bank;
          swap_pending <= 1'b0;
        end
      end else if (swap_req) begin
        if (busy && !done) swap_pending <= 1'b1;
        else               active_bank  <= ~active_bank;
      end

      if (done)
        done_sticky <= 1'b1;
      else if (commit && (word_q == 10'd1) && wdata_q[3])
        done_sticky <= 1'b0;

      if (commit) begin
        case (word_q)
          10'd0: begin
            irq_en <= wdata_q[2];
            start  <= wdata_q[0];
          end
          10'd2:   ile_wsp    <= wdata_q[CW:0];
          10'd3:   ile_probek <= wdata_q[SAMPLES_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_b) begin
    if (commit && (word_q >= 10'd256))
      coef_mem[~active_bank][idx_q] <= wdata_q[COEF_W-1:0];
    ram_rd_q <= coef_mem[~active_bank][acc_idx];
  end

  assign PREADY  = (state_q == S_RESP);
  assign PSLVERR = (state_q == S_RESP) && err_q;
  assign PRDATA  = ((state_q == S_RESP) && !wr_q && !err_q) ? prdata_q : '0;
  assign irq     = done_sticky & irq_en;

  assign unused_ok = ^{PADDR[31:12], PADDR[1:0], wdata_q};

endmodule

// File: doc/fir_coef_bank.md
# fir_coef_bank

Parametrised, double-buffered coefficient store and control-register file for the FIR engine, reached directly over APB on the FIR clock with no CDC stage. Software writes the shadow coefficient bank while the FIR reads the active bank. The banks swap on request, either immediately when the FIR is idle or deferred to the FIR's `done`. Protocol violations are reported on PSLVERR, and a maskable completion interrupt is provided.

## Interface
- `NUM_COEF`, 32: coefficients per bank; `CW = $clog2(NUM_COEF)`.
- `COEF_W`, 16: coefficient width; must be ≤ 32.
- `SAMPLES_W`, 14: width of `ile_probek`.
- `clk_b` in 1: the only clock; APB and FIR side both use it.
- `rst` in 1: synchronous, active-high reset.
- `PADDR` in 32: APB byte address; only `PADDR[11:2]` is decoded.
- `PSEL`, `PENABLE`, `PWRITE` in 1 each: APB control.
- `PWDATA` in 32: APB write data.
- `PREADY` out 1: APB transfer complete.
- `PRDATA` out 32: APB read data.
- `PSLVERR` out 1: APB error, valid with `PREADY`.
- `fir_coef_addr` in CW: FIR coefficient index into the active bank.
- `fir_coef_data` out COEF_W: coefficient at `fir_coef_addr`, registered.
- `start` out 1: one-cycle FIR start pulse.
- `busy` in 1: FIR running.
- `done` in 1: one-cycle FIR completion pulse.
- `ile_wsp` out CW+1: number of taps.
- `ile_probek` out SAMPLES_W: number of samples.
- `irq` out 1: `done_sticky & IRQ_EN`.

## Operation
Address map (byte offsets):
- 0x000 CTRL (W):
  - bit0 START: write 1 to pulse `start`.
  - bit1 SWAP: write 1 to request a bank swap.
  - bit2 IRQ_EN: read/write.
  - Reads return `{29'b0, IRQ_EN, 2'b0}`.
- 0x004 STATUS:
  - Read fields: bit0 `busy`, bit1 `active_bank`, bit2 `swap_pending`, bit3 `done_sticky`.
  - Writing 1 to bit3 clears `done_sticky`; other bits are ignored.
- 0x008 ILE_WSP: read/write.
- 0x00C ILE_PROBEK: read/write.
- 0x400 + 4·i, for i < NUM_COEF: coefficient i of the shadow bank (`!active_bank`), read/write. Read data is zero-extended.

PSLVERR=1 with PREADY=1, and no state change, for any of:
- an unmapped address, or a coefficient index ≥ NUM_COEF;
- a write of START=1 while `busy`;
- a write to ILE_WSP or ILE_PROBEK while `busy`;
- a write to ILE_WSP of 0 or of a value > NUM_COEF.

Bank swap:
- SWAP written while `!busy`: `active_bank` toggles at the write's completing edge.
- SWAP written while `busy`: `swap_pending` is set. On the next `done`, `active_bank` toggles and `swap_pending` clears.
- SWAP written while already pending: no effect and no error.
- START and SWAP in the same write while idle: the swap happens first, so `start` sees the new bank.

`done_sticky`:
- Set by `done`.
- Cleared by a W1C write to STATUS bit3.
- If set and clear occur in the same cycle, set wins.

Coefficient writes to the shadow bank are always legal, including while `busy` or while a swap is pending.

APB FSM (IDLE, RAM_WAIT, RESP):
- IDLE → RESP: on ACCESS (`PSEL & PENABLE`) for any write, any register read, or any error.
- IDLE → RAM_WAIT: on ACCESS for a valid coefficient read.
- RAM_WAIT → RESP: unconditionally.
- RESP → IDLE: unconditionally.
- PREADY=1 only in RESP.
- PRDATA is nonzero only in RESP of a successful read; otherwise it is 0.

Reset values:
- `PREADY`=0, `PRDATA`=0, `PSLVERR`=0, `start`=0, `irq`=0.
- `ile_wsp`=NUM_COEF, `ile_probek`=0, `fir_coef_data`=0.
- `active_bank`=0, `swap_pending`=0, `done_sticky`=0, IRQ_EN=0.
- Coefficient RAMs are not reset.

## Timing
- Writes and register reads take 1 wait state: ACCESS at cycle n, PREADY=1 at n+1.
- Coefficient reads take 2 wait states: synchronous RAM, so PREADY=1 at n+2.
- Writes commit at the edge ending cycle n+1, concurrent with PREADY.
- `start` is high for exactly the cycle after that commit edge.
- `fir_coef_data` has 1-cycle latency from `fir_coef_addr` and reads the active bank.
- A swap affects `fir_coef_data` from the second cycle after the swap edge.
- `done` and a SWAP write in the same cycle while `busy`=1: the swap is applied once, and `swap_pending` ends at 0.
- `rst` asserted mid-transfer: the FSM goes to IDLE, PREADY=0, and the pending write is discarded. The master must restart the transfer.
- PSEL dropped before PREADY is a protocol violation; the FSM still completes to IDLE.

## Test plan
1. **Reset defaults.** Assert reset, then read STATUS and ILE_WSP → 0x0 and 0x20; `irq`=0.
2. **Shadow write/read.** Write coefficient 5 = 0xBEEF → PREADY after 1 wait state. Read it back → 0x0000BEEF after 2 wait states. With `fir_coef_addr`=5, `fir_coef_data` ≠ 0xBEEF until SWAP; after SWAP, 0xBEEF appears 2 cycles after the swap edge.
3. **Deferred swap.** With `busy`=1, write SWAP → STATUS=0x5. Pulse `done` → STATUS=0xA, and `active_bank`=1.
4. **Busy errors.** With `busy`=1, write START, then write ILE_WSP=8 → PSLVERR=1 both times, `start` stays 0, ILE_WSP stays 0x20. Write ILE_WSP=33 while idle → PSLVERR=1.
5. **Out-of-range access.** Read 0x400 + 4·32 and read 0x010 → PSLVERR=1, PRDATA=0.
6. **Interrupt.** Set IRQ_EN, pulse `done` → `irq`=1 next cycle. Write 0x8 to STATUS in the same cycle as another `done` → `irq` stays 1. A later clear → `irq`=0.
